// File: rtl/hpi_pkg.sv
// Shared types for the HPI target model.
// Contents:
//   hpi_reg_e    - HPI register select decoded from OTG_ADDR
//   hpi_state_e  - bus access FSM state
//   STAT_*       - bit positions inside the STATUS register
package hpi_pkg;

  typedef enum logic [1:0] {
    HPI_DATA = 2'd0,
    HPI_MBX  = 2'd1,
    HPI_ADDR = 2'd2,
    HPI_STAT = 2'd3
  } hpi_reg_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_ACT = 2'd1,
    ST_WR_ACT = 2'd2
  } hpi_state_e;

  // STATUS[0]: device->host mailbox word pending (mirrors OTG_INT)
  // STATUS[1]: host->device mailbox word waiting for the local agent
  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_RX_VALID = 1;

endpackage

// File: rtl/hpi_strobe_sync.sv
// Synchronizer for one active-low HPI strobe pin.
// Ports:
//   clk, rst  - system clock, async active-high reset
//   d         - raw strobe pin (active low, asynchronous to clk)
//   q         - strobe after STAGES flops
// The chain resets to 1 so that a reset never looks like an asserted strobe.
module hpi_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/hpi_target_model.sv
// Responder side of the CY7C67200 HPI bus: decodes OTG_ADDR/CS_N/RD_N/WR_N
// and serves DATA/MAILBOX/ADDRESS/STATUS backed by an internal word RAM.
// Ports:
//   Clk, Reset                      - system clock, async active-high reset
//   OTG_ADDR/CS_N/RD_N/WR_N         - host bus control (strobes active low)
//   OTG_DATA_IN/OUT/OE              - host bus data, target drives when OE=1
//   OTG_INT                         - device->host mailbox word pending
//   mbx_tx_data/valid/ready         - local agent writes device->host mailbox
//   mbx_rx_data/valid/ack           - local agent consumes host->device mailbox
module hpi_target_model
  import hpi_pkg::*;
#(
  parameter int MEM_AW      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic [15:0] OTG_DATA_IN,
  output logic [15:0] OTG_DATA_OUT,
  output logic        OTG_DATA_OE,
  output logic        OTG_INT,
  input  logic [15:0] mbx_tx_data,
  input  logic        mbx_tx_valid,
  output logic        mbx_tx_ready,
  output logic [15:0] mbx_rx_data,
  output logic        mbx_rx_valid,
  input  logic        mbx_rx_ack
);

  // HPI address is a byte address; one extra bit above the word index
  localparam int AW = MEM_AW + 1;

  logic cs_s, rd_s, wr_s;
  logic [1:0]  addr_r;
  logic [15:0] din_r;

  hpi_strobe_sync #(.STAGES(SYNC_STAGES)) u_cs (.clk(Clk), .rst(Reset), .d(OTG_CS_N), .q(cs_s));
  hpi_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd (.clk(Clk), .rst(Reset), .d(OTG_RD_N), .q(rd_s));
  hpi_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr (.clk(Clk), .rst(Reset), .d(OTG_WR_N), .q(wr_s));

  // Address/data captured once, alongside the last strobe stage; the host holds
  // them stable for the whole strobe, so one flop is enough.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_r <= '0;
      din_r  <= '0;
    end else begin
      addr_r <= OTG_ADDR;
      din_r  <= OTG_DATA_IN;
    end
  end

  logic rd_act, wr_act;
  assign rd_act = ~cs_s & ~rd_s;
  assign wr_act = ~cs_s & ~wr_s;

  hpi_state_e      state;
  hpi_reg_e        cur_reg;
  hpi_reg_e        sel_reg;
  logic [AW-1:0]   hpi_addr;
  logic [MEM_AW-1:0] ram_idx;
  logic            tx_full, rx_valid;
  logic [15:0]     tx_word, rx_data, rd_word;
  logic            enter_wr, exit_rd;

  logic [15:0] ram [0:(1<<MEM_AW)-1];

  assign sel_reg  = hpi_reg_e'(addr_r);
  assign ram_idx  = hpi_addr[AW-1:1];
  // Read has priority when both strobes are seen together
  assign enter_wr = (state == ST_IDLE) && !rd_act && wr_act;
  assign exit_rd  = (state == ST_RD_ACT) && !rd_act;

  always_comb begin
    rd_word = '0;
    unique case (sel_reg)
      HPI_DATA: rd_word = ram[ram_idx];
      HPI_MBX:  rd_word = tx_word;
      HPI_ADDR: rd_word = 16'(hpi_addr);
      HPI_STAT: begin
        rd_word[STAT_TX_FULL]  = tx_full;
        rd_word[STAT_RX_VALID] = rx_valid;
      end
    endcase
  end

  // RAM contents survive reset; an aborted access never reaches enter_wr
  // because reset holds the synchronizers inactive.
  always_ff @(posedge Clk) begin
    if (enter_wr && sel_reg == HPI_DATA) ram[ram_idx] <= din_r;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      cur_reg      <= HPI_DATA;
      OTG_DATA_OUT <= '0;
      OTG_DATA_OE  <= 1'b0;
      hpi_addr     <= '0;
      tx_full      <= 1'b0;
      tx_word      <= '0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rd_act) begin
            state        <= ST_RD_ACT;
            cur_reg      <= sel_reg;
            OTG_DATA_OUT <= rd_word;
            OTG_DATA_OE  <= 1'b1;
          end else if (wr_act) begin
            state   <= ST_WR_ACT;
            cur_reg <= sel_reg;
            if (sel_reg == HPI_ADDR) hpi_addr <= {din_r[AW-1:1], 1'b0};
          end
        end
        ST_RD_ACT: begin
          if (!rd_act) begin
            state       <= ST_IDLE;
            OTG_DATA_OE <= 1'b0;
            if (cur_reg == HPI_DATA) hpi_addr <= hpi_addr + AW'(2);
          end
        end
        ST_WR_ACT: begin
          if (!wr_act) begin
            state <= ST_IDLE;
            if (cur_reg == HPI_DATA) hpi_addr <= hpi_addr + AW'(2);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Local write beats a same-cycle host mailbox read clear
      if (mbx_tx_valid && !tx_full) begin
        tx_full <= 1'b1;
        tx_word <= mbx_tx_data;
      end else if (exit_rd && cur_reg == HPI_MBX) begin
        tx_full <= 1'b0;
      end

      // Host mailbox write beats a same-cycle local ack
      if (enter_wr && sel_reg == HPI_MBX) begin
        rx_valid <= 1'b1;
        rx_data  <= din_r;
      end else if (mbx_rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign OTG_INT      = tx_full;
  assign mbx_tx_ready = ~tx_full;
  assign mbx_rx_valid = rx_valid;
  assign mbx_rx_data  = rx_data;

endmodule

// File: tb/tb_hpi_target_model.sv
// Self-checking bench for hpi_target_model: directed HPI scenarios plus a
// randomized mix of host and local-agent operations checked against a
// transaction-level model (register values, byte address, sparse memory).
module tb_hpi_target_model;

  localparam int MEM_AW = 8;
  localparam int SYNC   = 2;
  localparam int AMOD   = 1 << (MEM_AW + 1);

  localparam logic [1:0] R_DATA = 2'd0, R_MBX = 2'd1, R_ADDR = 2'd2, R_STAT = 2'd3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  OTG_ADDR;
  logic        OTG_CS_N, OTG_RD_N, OTG_WR_N;
  logic [15:0] OTG_DATA_IN, OTG_DATA_OUT;
  logic        OTG_DATA_OE, OTG_INT;
  logic [15:0] mbx_tx_data, mbx_rx_data;
  logic        mbx_tx_valid, mbx_tx_ready, mbx_rx_valid, mbx_rx_ack;

  hpi_target_model #(.MEM_AW(MEM_AW), .SYNC_STAGES(SYNC)) dut (
    .Clk(Clk), .Reset(Reset),
    .OTG_ADDR(OTG_ADDR), .OTG_CS_N(OTG_CS_N), .OTG_RD_N(OTG_RD_N), .OTG_WR_N(OTG_WR_N),
    .OTG_DATA_IN(OTG_DATA_IN), .OTG_DATA_OUT(OTG_DATA_OUT), .OTG_DATA_OE(OTG_DATA_OE),
    .OTG_INT(OTG_INT),
    .mbx_tx_data(mbx_tx_data), .mbx_tx_valid(mbx_tx_valid), .mbx_tx_ready(mbx_tx_ready),
    .mbx_rx_data(mbx_rx_data), .mbx_rx_valid(mbx_rx_valid), .mbx_rx_ack(mbx_rx_ack)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [15:0] m_mem [int];
  int          m_addr;
  bit          m_tx_full, m_rx_valid;
  logic [15:0] m_tx_word, m_rx_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_tx_full = 0; m_tx_word = '0; m_rx_valid = 0; m_rx_data = '0;
  endtask

  task automatic chk_side(input string tag);
    chk({tag, "_int"},   OTG_INT,      m_tx_full);
    chk({tag, "_txrdy"}, mbx_tx_ready, !m_tx_full);
    chk({tag, "_rxv"},   mbx_rx_valid, m_rx_valid);
    if (m_rx_valid) chk({tag, "_rxd"}, mbx_rx_data, m_rx_data);
  endtask

  // Host write; with ack_at_commit the local ack lands on the commit clock.
  task automatic host_write(input logic [1:0] r, input logic [15:0] v, input bit ack_at_commit);
    @(negedge Clk);
    OTG_ADDR = r; OTG_DATA_IN = v; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
    if (ack_at_commit) begin
      repeat (SYNC) @(negedge Clk);
      mbx_rx_ack = 1'b1;
      @(negedge Clk);
      mbx_rx_ack = 1'b0;
      repeat (3) @(negedge Clk);
    end else begin
      repeat (SYNC + 4) @(negedge Clk);
    end
    OTG_CS_N = 1'b1; OTG_WR_N = 1'b1;
    repeat (SYNC + 3) @(negedge Clk);
    case (r)
      R_DATA: begin m_mem[m_addr >> 1] = v; m_addr = (m_addr + 2) % AMOD; end
      R_MBX:  begin m_rx_valid = 1; m_rx_data = v; end
      R_ADDR: m_addr = v & (AMOD - 2);
      default: ;
    endcase
  endtask

  // Host read: checks OE latency, value against the model, OE release.
  task automatic host_read(input logic [1:0] r, output logic [15:0] d);
    int n;
    bit known;
    logic [15:0] exp;
    known = 1;
    case (r)
      R_DATA: begin
        known = m_mem.exists(m_addr >> 1);
        exp = known ? m_mem[m_addr >> 1] : 16'h0;
      end
      R_MBX:  begin known = m_tx_full; exp = m_tx_word; end
      R_ADDR: exp = 16'(m_addr);
      default: exp = {14'b0, m_rx_valid, m_tx_full};
    endcase
    @(negedge Clk);
    OTG_ADDR = r; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    n = 0;
    while (!OTG_DATA_OE && n < 20) begin @(negedge Clk); n++; end
    chk("rd_lat", n, SYNC + 1);
    d = OTG_DATA_OUT;
    if (known) chk($sformatf("rd_r%0d", r), d, exp);
    repeat (3) @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
    n = 0;
    while (OTG_DATA_OE && n < 20) begin @(negedge Clk); n++; end
    chk("rd_oe_off", OTG_DATA_OE, 1'b0);
    repeat (2) @(negedge Clk);
    if (r == R_DATA) m_addr = (m_addr + 2) % AMOD;
    if (r == R_MBX)  m_tx_full = 0;
  endtask

  task automatic local_tx(input logic [15:0] v);
    @(negedge Clk);
    mbx_tx_valid = 1'b1; mbx_tx_data = v;
    @(negedge Clk);
    mbx_tx_valid = 1'b0;
    if (!m_tx_full) begin m_tx_full = 1; m_tx_word = v; end
  endtask

  task automatic local_ack();
    @(negedge Clk);
    mbx_rx_ack = 1'b1;
    @(negedge Clk);
    mbx_rx_ack = 1'b0;
    m_rx_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    int n;
    Reset = 1'b1; OTG_ADDR = '0; OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; OTG_WR_N = 1'b1;
    OTG_DATA_IN = '0; mbx_tx_data = '0; mbx_tx_valid = 1'b0; mbx_rx_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    chk("rst_oe",   OTG_DATA_OE,  1'b0);
    chk("rst_dout", OTG_DATA_OUT, 16'h0);
    chk("rst_rxd",  mbx_rx_data,  16'h0);
    chk_side("rst");
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // sequential DATA access with auto-increment
    host_write(R_ADDR, 16'h0010, 0);
    host_write(R_DATA, 16'hBEEF, 0);
    host_write(R_DATA, 16'hCAFE, 0);
    host_write(R_ADDR, 16'h0010, 0);
    host_read(R_DATA, d); chk("seq0", d, 16'hBEEF);
    host_read(R_DATA, d); chk("seq1", d, 16'hCAFE);
    host_read(R_ADDR, d); chk("seq_addr", d, 16'h0014);

    // address wrap at top of RAM
    host_write(R_ADDR, 16'(AMOD - 2), 0);
    host_write(R_DATA, 16'h1234, 0);
    host_read(R_ADDR, d); chk("wrap_addr", d, 16'h0000);
    host_write(R_ADDR, 16'(AMOD - 2), 0);
    host_read(R_DATA, d); chk("wrap_data", d, 16'h1234);

    // device->host mailbox
    local_tx(16'h00A5);
    @(negedge Clk);
    chk("tx_int", OTG_INT, 1'b1);
    host_read(R_STAT, d); chk("tx_stat", d, 16'h0001);
    host_read(R_MBX, d);  chk("tx_word", d, 16'h00A5);
    chk("tx_int_clr", OTG_INT, 1'b0);
    host_read(R_STAT, d); chk("tx_stat_clr", d, 16'h0000);

    // host->device mailbox
    host_write(R_MBX, 16'h5A5A, 0);
    chk("rx_v", mbx_rx_valid, 1'b1);
    chk("rx_d", mbx_rx_data, 16'h5A5A);
    host_read(R_STAT, d); chk("rx_stat", d, 16'h0002);
    local_ack();
    chk("rx_ack", mbx_rx_valid, 1'b0);

    // ack on the commit clock loses to the host write
    host_write(R_MBX, 16'h0101, 1);
    chk("race_v", mbx_rx_valid, 1'b1);
    chk("race_d", mbx_rx_data, 16'h0101);
    local_ack();
    chk_side("dir_end");

    // randomized mix
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0:    host_write(R_ADDR, 16'($urandom), 0);
        1, 2: host_write(R_DATA, 16'($urandom), 0);
        3, 4: host_read(R_DATA, d);
        5:    host_read(R_ADDR, d);
        6:    local_tx(16'($urandom));
        7:    host_read(($urandom_range(0, 1) != 0) ? R_MBX : R_STAT, d);
        8:    host_write(R_MBX, 16'($urandom), $urandom_range(0, 1) != 0);
        default: begin
          if ($urandom_range(0, 1) != 0) local_ack();
          else host_write(R_STAT, 16'($urandom), 0);
        end
      endcase
      chk_side($sformatf("rnd%0d", i));
    end

    // reset in the middle of a DATA read
    host_write(R_ADDR, 16'h0020, 0);
    local_tx(16'h7777);
    host_write(R_MBX, 16'h3333, 0);
    @(negedge Clk);
    OTG_ADDR = R_DATA; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    n = 0;
    while (!OTG_DATA_OE && n < 20) begin @(negedge Clk); n++; end
    chk("rr_oe_on", OTG_DATA_OE, 1'b1);
    #2 Reset = 1'b1;
    #1;
    chk("rr_oe",   OTG_DATA_OE,  1'b0);
    chk("rr_dout", OTG_DATA_OUT, 16'h0);
    chk("rr_rxd",  mbx_rx_data,  16'h0);
    model_reset();
    chk_side("rr");
    @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (SYNC + 3) @(negedge Clk);
    host_read(R_ADDR, d); chk("rr_addr", d, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
